sa_out_drain: RTL and testbench

SA_OUT_DRAIN -- requirements
Module: sa_out_drain

---
 rtl/sa_out_drain.sv | 117 +++++++++++
 tb/tb_sa_out_drain.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_out_drain.sv
// Drains a systolic-array result matrix row by row over a valid/ready handshake.
// The matrix is snapshotted on the rising edge of I_OUT_VLD so the array can be re-armed early.
module sa_out_drain #(
  parameter int D_W  = 16,
  parameter int SA_R = 16,
  parameter int SA_C = 16
) (
  input  logic                                  I_CLK,
  input  logic                                  I_ASYN_RSTN,
  input  logic                                  I_SYNC_RSTN,
  input  logic                                  I_OUT_VLD,
  input  logic [SA_R-1:0][SA_C-1:0][D_W-1:0]    I_OUT,
  input  logic                                  I_ROW_RDY,
  output logic                                  O_ROW_VLD,
  output logic [SA_C-1:0][D_W-1:0]              O_ROW,
  output logic [$clog2(SA_R)-1:0]               O_ROW_IDX,
  output logic                                  O_LAST,
  output logic                                  O_DONE,
  output logic                                  O_SA_CLR,
  output logic                                  O_OVERRUN,
  output logic                                  O_BUSY
);

  localparam int                IDX_W    = $clog2(SA_R);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(SA_R - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_SEND = 3'b010,
    S_DONE = 3'b100
  } state_t;

  state_t                             state;
  logic                               vld_q;
  logic [SA_R-1:0][SA_C-1:0][D_W-1:0] snap;
  logic [IDX_W-1:0]                   row_cnt;
  logic [IDX_W-1:0]                   next_idx;
  logic                               vld_rise;
  logic                               transfer;

  assign vld_rise  = I_OUT_VLD & ~vld_q;
  assign transfer  = O_ROW_VLD & I_ROW_RDY;
  assign next_idx  = row_cnt + 1'b1;
  assign O_ROW_IDX = row_cnt;

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      state     <= S_IDLE;
      vld_q     <= 1'b0;
      // NOTE: the snapshot buffer is reset on purpose so a drain after reset never exposes stale data.
      snap      <= '0;
      row_cnt   <= '0;
      O_ROW     <= '0;
      O_ROW_VLD <= 1'b0;
      O_LAST    <= 1'b0;
      O_DONE    <= 1'b0;
      O_SA_CLR  <= 1'b0;
      O_OVERRUN <= 1'b0;
      O_BUSY    <= 1'b0;
    end else if (!I_SYNC_RSTN) begin
      state     <= S_IDLE;
      vld_q     <= 1'b0;
      snap      <= '0;
      row_cnt   <= '0;
      O_ROW     <= '0;
      O_ROW_VLD <= 1'b0;
      O_LAST    <= 1'b0;
      O_DONE    <= 1'b0;
      O_SA_CLR  <= 1'b0;
      O_OVERRUN <= 1'b0;
      O_BUSY    <= 1'b0;
    end else begin
      vld_q <= I_OUT_VLD;

      // A new result arriving while a drain is in flight is dropped and flagged.
      if (vld_rise && (state != S_IDLE)) O_OVERRUN <= 1'b1;

      unique case (state)
        S_IDLE: begin
          if (vld_rise) begin
            snap      <= I_OUT;
            row_cnt   <= '0;
            O_ROW     <= I_OUT[0];
            O_ROW_VLD <= 1'b1;
            O_LAST    <= (LAST_IDX == '0);
            O_BUSY    <= 1'b1;
            state     <= S_SEND;
          end
        end
        S_SEND: begin
          if (transfer) begin
            if (row_cnt == LAST_IDX) begin
              O_ROW_VLD <= 1'b0;
              O_LAST    <= 1'b0;
              O_DONE    <= 1'b1;
              O_SA_CLR  <= 1'b1;
              state     <= S_DONE;
            end else begin
              row_cnt <= next_idx;
              O_ROW   <= snap[next_idx];
              O_LAST  <= (next_idx == LAST_IDX);
            end
          end
        end
        S_DONE: begin
          O_DONE   <= 1'b0;
          O_SA_CLR <= 1'b0;
          O_BUSY   <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sa_out_drain.sv
// Directed-sequence bench for sa_out_drain with randomized matrices and ready patterns.
// Expected rows come from a captured copy of the matrix and an in-order row index model.
module tb_sa_out_drain;

  localparam int D_W   = 16;
  localparam int SA_R  = 16;
  localparam int SA_C  = 16;
  localparam int IDX_W = $clog2(SA_R);
  localparam int ROW_W = SA_C * D_W;

  logic                               clk = 1'b0;
  logic                               rst_n;
  logic                               sync_rstn;
  logic                               out_vld;
  logic [SA_R-1:0][SA_C-1:0][D_W-1:0] out_mat;
  logic [SA_R-1:0][SA_C-1:0][D_W-1:0] exp_mat;
  logic                               row_rdy;
  logic                               row_vld;
  logic [SA_C-1:0][D_W-1:0]           row;
  logic [IDX_W-1:0]                   row_idx;
  logic                               last;
  logic                               done;
  logic                               sa_clr;
  logic                               overrun;
  logic                               busy;

  int n_cmp = 0;
  int n_bad = 0;
  bit m_ovr = 1'b0;
  bit aborted;

  sa_out_drain #(.D_W(D_W), .SA_R(SA_R), .SA_C(SA_C)) dut (
    .I_CLK       (clk),
    .I_ASYN_RSTN (rst_n),
    .I_SYNC_RSTN (sync_rstn),
    .I_OUT_VLD   (out_vld),
    .I_OUT       (out_mat),
    .I_ROW_RDY   (row_rdy),
    .O_ROW_VLD   (row_vld),
    .O_ROW       (row),
    .O_ROW_IDX   (row_idx),
    .O_LAST      (last),
    .O_DONE      (done),
    .O_SA_CLR    (sa_clr),
    .O_OVERRUN   (overrun),
    .O_BUSY      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_row_vld"}, ROW_W'(row_vld), ROW_W'(0));
    check({tag, "_row"},     row,             '0);
    check({tag, "_row_idx"}, ROW_W'(row_idx), ROW_W'(0));
    check({tag, "_last"},    ROW_W'(last),    ROW_W'(0));
    check({tag, "_done"},    ROW_W'(done),    ROW_W'(0));
    check({tag, "_sa_clr"},  ROW_W'(sa_clr),  ROW_W'(0));
    check({tag, "_overrun"}, ROW_W'(overrun), ROW_W'(0));
    check({tag, "_busy"},    ROW_W'(busy),    ROW_W'(0));
  endtask

  task automatic fill_random();
    for (int r = 0; r < SA_R; r++)
      for (int c = 0; c < SA_C; c++)
        out_mat[r][c] = D_W'($urandom);
  endtask

  task automatic lower_vld();
    out_vld = 1'b0;
    @(negedge clk);
  endtask

  // Rising I_OUT_VLD: the model captures the matrix the DUT is expected to snapshot.
  task automatic raise_vld();
    check("idle_before_rise", ROW_W'(row_vld), ROW_W'(0));
    out_vld = 1'b1;
    exp_mat = out_mat;
    @(negedge clk);
  endtask

  task automatic idle_check(input int n);
    repeat (n) begin
      @(negedge clk);
      check("idle_row_vld", ROW_W'(row_vld), ROW_W'(0));
      check("idle_busy",    ROW_W'(busy),    ROW_W'(0));
      check("idle_overrun", ROW_W'(overrun), ROW_W'(m_ovr));
    end
  endtask

  // Expects every row 0..SA_R-1 in order, exactly once, then a single done cycle.
  // mode: 0 ready always, 1 ready pattern 1,0,0, 2 random ready.
  // hook: 1 corrupt I_OUT, 2 re-raise valid, 3 async reset, 4 sync reset, 5 probe row5/col3.
  task automatic drain(input int mode, input int hook, input int hook_row, input bit rearm,
                       output bit was_aborted);
    int exp_idx = 0;
    int cyc = 0;
    int phase = 0;
    bit ovr_pending;
    was_aborted = 1'b0;
    while (exp_idx < SA_R && cyc < 400) begin
      check("row_vld",  ROW_W'(row_vld), ROW_W'(1));
      check("row_idx",  ROW_W'(row_idx), ROW_W'(exp_idx));
      check("row_data", row,             exp_mat[exp_idx]);
      check("last",     ROW_W'(last),    ROW_W'(exp_idx == SA_R - 1));
      check("busy",     ROW_W'(busy),    ROW_W'(1));
      check("done",     ROW_W'(done),    ROW_W'(0));
      check("overrun",  ROW_W'(overrun), ROW_W'(m_ovr));
      ovr_pending = 1'b0;
      case (mode)
        0:       row_rdy = 1'b1;
        1:       row_rdy = ((cyc % 3) == 0);
        default: row_rdy = 1'($urandom_range(0, 1));
      endcase
      if ((phase == 0 && exp_idx == hook_row) || phase == 1) begin
        case (hook)
          1: begin
            out_mat = {(SA_R * SA_C){16'h7FFF}};
            phase = 2;
          end
          2: begin
            if (phase == 0) begin
              out_vld = 1'b0;
              phase = 1;
            end else begin
              out_vld = 1'b1;
              ovr_pending = 1'b1;
              phase = 2;
            end
          end
          3: begin
            row_rdy = 1'b0;
            rst_n = 1'b0;
            #1;
            m_ovr = 1'b0;
            check_reset_outputs("async");
            repeat (2) begin
              @(negedge clk);
              check("async_hold_done",    ROW_W'(done),    ROW_W'(0));
              check("async_hold_row_vld", ROW_W'(row_vld), ROW_W'(0));
            end
            rst_n = 1'b1;
            @(negedge clk);
            was_aborted = 1'b1;
            return;
          end
          4: begin
            row_rdy = 1'b0;
            sync_rstn = 1'b0;
            out_vld = 1'b0;
            @(negedge clk);
            sync_rstn = 1'b1;
            m_ovr = 1'b0;
            check_reset_outputs("sync");
            @(negedge clk);
            check("sync_after_done",    ROW_W'(done),    ROW_W'(0));
            check("sync_after_row_vld", ROW_W'(row_vld), ROW_W'(0));
            was_aborted = 1'b1;
            return;
          end
          5: begin
            check("row5_col3", ROW_W'(row[3]), ROW_W'(16'h0053));
            phase = 2;
          end
          default: phase = 2;
        endcase
      end
      @(negedge clk);
      cyc++;
      if (row_rdy) exp_idx++;
      if (ovr_pending) m_ovr = 1'b1;
    end
    check("drain_rows", ROW_W'(exp_idx), ROW_W'(SA_R));
    if (exp_idx != SA_R) return;
    if (mode == 0) check("drain_cycles", ROW_W'(cyc), ROW_W'(SA_R));
    check("done_pulse",    ROW_W'(done),    ROW_W'(1));
    check("sa_clr_pulse",  ROW_W'(sa_clr),  ROW_W'(1));
    check("done_row_vld",  ROW_W'(row_vld), ROW_W'(0));
    check("done_last",     ROW_W'(last),    ROW_W'(0));
    check("done_busy",     ROW_W'(busy),    ROW_W'(1));
    check("done_overrun",  ROW_W'(overrun), ROW_W'(m_ovr));
    if (rearm) out_vld = 1'b0;
    @(negedge clk);
    check("post_done",     ROW_W'(done),    ROW_W'(0));
    check("post_sa_clr",   ROW_W'(sa_clr),  ROW_W'(0));
    check("post_busy",     ROW_W'(busy),    ROW_W'(0));
    check("post_row_vld",  ROW_W'(row_vld), ROW_W'(0));
    if (rearm) begin
      fill_random();
      out_vld = 1'b1;
      exp_mat = out_mat;
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    sync_rstn = 1'b1;
    out_vld   = 1'b0;
    row_rdy   = 1'b0;
    out_mat   = '0;
    exp_mat   = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(negedge clk);

    // Incrementing matrix, ready held high.
    for (int r = 0; r < SA_R; r++)
      for (int c = 0; c < SA_C; c++)
        out_mat[r][c] = D_W'(r * 16 + c);
    raise_vld();
    drain(0, 5, 5, 1'b0, aborted);
    idle_check(3);

    // Stalling ready pattern 1,0,0.
    lower_vld();
    raise_vld();
    drain(1, 0, -1, 1'b0, aborted);

    // I_OUT overwritten mid-drain, then re-arm as the FSM returns to idle.
    lower_vld();
    fill_random();
    raise_vld();
    drain(0, 1, 4, 1'b1, aborted);
    drain(2, 0, -1, 1'b0, aborted);

    // Valid re-raised mid-drain: overrun, drain continues, no second drain.
    lower_vld();
    fill_random();
    raise_vld();
    drain(0, 2, 8, 1'b0, aborted);
    idle_check(4);

    // Synchronous reset in the middle of a drain clears overrun.
    lower_vld();
    fill_random();
    raise_vld();
    drain(2, 4, 3, 1'b0, aborted);
    idle_check(2);

    // Asynchronous reset at row 6 with valid still high: fresh drain afterwards.
    lower_vld();
    fill_random();
    raise_vld();
    drain(0, 3, 6, 1'b0, aborted);
    drain(0, 0, -1, 1'b0, aborted);
    idle_check(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
